// File: rtl/lfsr_period_ctrl_if.sv
// Host/LFSR-facing signal bundle for lfsr_period_ctrl.
// master: the sequencer and LFSR side; slave: the controller.
interface lfsr_period_ctrl_if #(
    parameter int unsigned LENGTH = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic [LENGTH-1:0] seed;
    logic [CNT_W-1:0]  max_count;
    logic [LENGTH-1:0] lfsr_data;
    logic              lfsr_load;
    logic [LENGTH-1:0] lfsr_seed;
    logic              lfsr_enable;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  period;
    logic              timeout;
    logic              lockup;

    modport master (
        output start, seed, max_count, lfsr_data,
        input  lfsr_load, lfsr_seed, lfsr_enable, busy, done, period, timeout, lockup
    );

    modport slave (
        input  start, seed, max_count, lfsr_data,
        output lfsr_load, lfsr_seed, lfsr_enable, busy, done, period, timeout, lockup
    );
endinterface

// File: rtl/lfsr_period_ctrl.sv
// Loads a seed into an LFSR, steps it and measures the cycle length back to the seed.
// Optional macro LFSR_LOCKUP_DETECT_EN: terminate on the all-zero lock-up state.
module lfsr_period_ctrl #(
    parameter int unsigned LENGTH = 8,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    lfsr_period_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e            state_q;
    logic [LENGTH-1:0] seed_q;
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  period_q;
    logic              load_q;
    logic              done_q;
    logic              timeout_q;
    logic              lockup_q;

    logic zero_hit;
    logic match_hit;
    logic limit_hit;
    logic term;

    always_comb begin
        zero_hit = 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
        zero_hit = (bus.lfsr_data == '0);
`endif
        // cnt==0 is the freshly loaded seed itself, not a return to it
        match_hit = (cnt_q != '0) && (bus.lfsr_data == seed_q);
        limit_hit = (cnt_q == max_q);
        term      = (state_q == StRun) && (zero_hit || match_hit || limit_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            seed_q    <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            lockup_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        seed_q    <= bus.seed;
                        max_q     <= bus.max_count;
                        period_q  <= '0;
                        timeout_q <= 1'b0;
                        lockup_q  <= 1'b0;
                        load_q    <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (term) begin
                        period_q  <= cnt_q;
                        lockup_q  <= zero_hit;
                        timeout_q <= !zero_hit && !match_hit;
                        done_q    <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.lfsr_load   = load_q;
    assign bus.lfsr_seed   = seed_q;
    assign bus.lfsr_enable = (state_q == StRun) && !term;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.period      = period_q;
    assign bus.timeout     = timeout_q;
    assign bus.lockup      = lockup_q;
endmodule
